reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Bus master for the internal 8-bit register bus (address / data / rd / wr) shared by all register, constant and FIFO-register slaves.
- Parses a host byte stream arriving on a valid/ready interface into read and write bursts.
- Sequences single-cycle bus_rd / bus_wr strobes and returns read bytes on a valid/ready output stream.
- Sits between the host transport (USB FIFO bridge) and the register bank.

Parameters:
- TIMEOUT, 16'd0: max cycles waiting for an expected rx byte mid-command before aborting; 0 = disabled.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- rx_data  in  8  host command/data byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  read-back byte to host
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  host accepts tx_data
- bus_address  out  8  register bus address
- bus_data  inout  8  register bus data, tristate
- bus_rd  out  1  read strobe, one cycle per byte
- bus_wr  out  1  write strobe, one cycle per byte
- busy  out  1  high whenever state != S_CMD
- err_timeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset and clock: reset nreset, synchronous, active-low; clock clk.
- Reset values: rx_ready=0 for the reset cycle, tx_valid=0, bus_rd=0, bus_wr=0, bus_address=8'h00, busy=0, err_timeout=0, bus_data=Z.
- Reset mid-operation discards the partial command and leaves any popped FIFO bytes lost.
- Byte transfer rule: a byte moves on any edge where valid && ready.
- Command byte fields:
  - bit7 = 1 write / 0 read.
  - bit6 = auto-increment.
  - bits5:0 = N-1, so N = 1..64 bytes.
- Command sequence: command byte, then address byte. A write is followed by N data bytes; a read returns N bytes on tx.
- S_CMD:
  - rx_ready=1.
  - On accept, latch dir, inc and cnt=N-1.
  - Go to S_ADDR.
- S_ADDR:
  - rx_ready=1.
  - On accept, load addr.
  - Go to S_WDATA if write, else S_RSTB.
- S_WDATA:
  - rx_ready=1.
  - On accept, latch the byte into wreg.
  - Go to S_WSTB.
- S_WSTB:
  - bus_wr=1 for exactly one cycle.
  - bus_address=addr; bus_data driven with wreg this cycle only.
  - Then: if cnt==0 go to S_CMD; else cnt--, addr+=inc, go to S_WDATA.
- S_RSTB:
  - bus_rd=1 for exactly one cycle with bus_address=addr.
  - bus_data sampled into the tx register at the closing edge.
  - Go to S_RSEND.
- S_RSEND:
  - tx_valid=1, tx_data stable until tx_ready.
  - On handshake: if cnt==0 go to S_CMD; else cnt--, addr+=inc, go to S_RSTB.
- Timing:
  - Write latency: data byte accepted at edge k → bus_wr high in cycle k+1.
  - Read latency: bus_rd one cycle after address accept or after the previous tx handshake; tx_valid the following cycle.
- Strobe exclusivity: bus_rd and bus_wr are never high together, and never high in consecutive cycles for the same byte. Each bus byte gets exactly one strobe, so FIFO registers pop or push once per byte.
- Bus drive: bus_data is Z in every state except S_WSTB. The master never drives while bus_rd=1.
- Address handling:
  - bus_address holds its last value between commands.
  - Auto-increment wraps 8'hFF → 8'h00 (8-bit modulo).
  - With inc=0 the address is fixed, which is the FIFO burst case.
- rx_ready is 0 in S_WSTB, S_RSTB and S_RSEND. Host bytes are back-pressured, never dropped.
- Timeout (TIMEOUT != 0):
  - A wait counter runs in S_ADDR and S_WDATA.
  - It clears on every rx accept and on state entry.
  - When it reaches TIMEOUT with no accept: err_timeout pulses one cycle and the state returns to S_CMD.
  - Bytes already written stay written.
- No timeout in S_RSEND: tx back-pressure is unbounded.
- Simultaneous events: there is no concurrency between rx and tx. The block is half-duplex by state, so simultaneous rx_valid and pending tx_valid is legal; rx waits.

Decomposition:
- Shared package reg_bus_pkg:
  - state enum (S_CMD, S_ADDR, S_WDATA, S_WSTB, S_RSTB, S_RSEND).
  - Command bit positions CMD_WR_BIT=7, CMD_INC_BIT=6, CMD_CNT_MSB=5.
  - Bus widths ADDR_W=8, DATA_W=8.
- No sub-module. The timeout counter and FSM are a single module; the tristate driver is a continuous assign.

Test Plan:
- Single write: rx 8'h80, 8'h12, 8'hA5 → one bus_wr pulse, bus_address=12, bus_data=A5 that cycle; busy returns 0; tx silent.
- Auto-increment read burst across wrap: rx 8'h42, 8'hFE with model regs FE=11, FF=22, 00=33.
  - tx emits 11, 22, 33.
  - Three bus_rd pulses at FE, FF, 00.
- Fixed-address FIFO read with tx back-pressure: rx 8'h03, 8'h20, tx_ready low 5 cycles per byte.
  - Exactly 4 bus_rd pulses at 20.
  - tx_data stable while stalled; bytes match FIFO order.
- Write burst with rx gaps: rx 8'hC2, 8'h40 then 3 bytes with 2-cycle valid gaps.
  - Writes land at 40, 41, 42.
  - bus_data Z outside bus_wr cycles.
- Timeout: TIMEOUT=8, rx 8'h81, 8'h10, 8'h55, then idle 8 cycles.
  - One write to 10.
  - err_timeout pulses, state returns to S_CMD.
  - Next rx 8'h00, 8'h10 reads 55.
- Reset mid-burst: nreset low during S_RSEND of a 4-byte read.
  - Next cycle tx_valid=0, bus_rd=0, busy=0, bus_address=00.
  - A fresh command then completes normally.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register bus master
//
// Purpose: FSM state encoding, command byte field positions and bus widths
// used by reg_bus_master and anything that decodes its command stream.
package reg_bus_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;

  // Command byte layout: [7] write, [6] auto-increment, [5:0] byte count - 1
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_INC_BIT = 6;
  localparam int CMD_CNT_MSB = 5;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WSTB,
    S_RSTB,
    S_RSEND
  } state_t;

  // States in which the master is stalled on the host mid-command and the
  // timeout watchdog is allowed to run.
  function automatic logic waits_for_rx(input state_t s);
    return (s == S_ADDR) || (s == S_WDATA);
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - host byte stream to 8-bit register bus master
//
// Purpose: parses {command, address, data...} bursts from the host stream,
// issues one bus_wr / bus_rd strobe per byte and returns read bytes on tx.
//
// Ports:
//   clk, nreset          clock, synchronous active-low reset
//   rx_data/valid/ready  host command and write-data bytes in
//   tx_data/valid/ready  read-back bytes out to host
//   bus_address          register bus address (holds between commands)
//   bus_data             bidirectional register bus data, driven only in S_WSTB
//   bus_rd, bus_wr       single-cycle strobes, one per byte
//   busy                 high whenever a command is in progress
//   err_timeout          one-cycle pulse when a stalled command is abandoned
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd0
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] bus_address,
  inout  wire  [DATA_W-1:0] bus_data,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic              busy,
  output logic              err_timeout
);

  state_t                 state;
  state_t                 state_next;

  logic                   dir;
  logic                   inc;
  logic [CMD_CNT_MSB:0]   cnt;
  logic [ADDR_W-1:0]      addr;
  logic [ADDR_W-1:0]      addr_step;
  logic [DATA_W-1:0]      wreg;
  logic [DATA_W-1:0]      txreg;
  logic [15:0]            wait_cnt;

  logic                   rx_fire;
  logic                   tx_fire;
  logic                   last_byte;
  logic                   timeout_hit;

  // Handshake outputs depend only on state; they are forced low while reset
  // is asserted so no byte is taken during the reset cycle.
  assign rx_ready = nreset && ((state == S_CMD) || (state == S_ADDR) || (state == S_WDATA));
  assign tx_valid = nreset && (state == S_RSEND);

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign last_byte = (cnt == '0);
  assign addr_step = {{(ADDR_W-1){1'b0}}, inc};

  // Fires in the TIMEOUT-th consecutive waiting cycle without an accept.
  assign timeout_hit = (TIMEOUT != 16'd0) && waits_for_rx(state) && !rx_fire &&
                       (wait_cnt == TIMEOUT - 16'd1);

  assign tx_data     = txreg;
  assign bus_address = addr;

  // Only the write strobe cycle drives the bus; slaves own it otherwise.
  assign bus_data = bus_wr ? wreg : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= S_CMD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    bus_rd      = 1'b0;
    bus_wr      = 1'b0;
    err_timeout = 1'b0;
    busy        = (state != S_CMD);

    case (state)
      S_CMD: begin
        if (rx_fire) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_fire) begin
          state_next = dir ? S_WDATA : S_RSTB;
        end else if (timeout_hit) begin
          state_next  = S_CMD;
          err_timeout = 1'b1;
        end
      end
      S_WDATA: begin
        if (rx_fire) begin
          state_next = S_WSTB;
        end else if (timeout_hit) begin
          state_next  = S_CMD;
          err_timeout = 1'b1;
        end
      end
      S_WSTB: begin
        bus_wr     = 1'b1;
        state_next = last_byte ? S_CMD : S_WDATA;
      end
      S_RSTB: begin
        bus_rd     = 1'b1;
        state_next = S_RSEND;
      end
      S_RSEND: begin
        if (tx_fire) begin
          state_next = last_byte ? S_CMD : S_RSTB;
        end
      end
      default: begin
        state_next = S_CMD;
      end
    endcase

    // Keep FIFO-register slaves from popping/pushing during the reset cycle.
    if (!nreset) begin
      bus_rd      = 1'b0;
      bus_wr      = 1'b0;
      err_timeout = 1'b0;
      busy        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      dir      <= 1'b0;
      inc      <= 1'b0;
      cnt      <= '0;
      addr     <= '0;
      wreg     <= '0;
      txreg    <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_fire) begin
            dir <= rx_data[CMD_WR_BIT];
            inc <= rx_data[CMD_INC_BIT];
            cnt <= rx_data[CMD_CNT_MSB:0];
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr <= rx_data;
          end
        end
        S_WDATA: begin
          if (rx_fire) begin
            wreg <= rx_data;
          end
        end
        S_WSTB: begin
          if (!last_byte) begin
            cnt  <= cnt - 1'b1;
            addr <= addr + addr_step;
          end
        end
        S_RSTB: begin
          txreg <= bus_data;
        end
        S_RSEND: begin
          if (tx_fire && !last_byte) begin
            cnt  <= cnt - 1'b1;
            addr <= addr + addr_step;
          end
        end
        default: begin
        end
      endcase

      // Entry into S_ADDR/S_WDATA always comes via an accept or a
      // non-waiting state, so clearing outside those states covers entry.
      if ((TIMEOUT == 16'd0) || !waits_for_rx(state) || rx_fire || timeout_hit) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed bench for reg_bus_master
module tb_reg_bus_master;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] bus_address;
  wire  [7:0] bus_data;
  logic       bus_rd;
  logic       bus_wr;
  logic       busy;
  logic       err_timeout;

  always #5 clk = ~clk;

  reg_bus_master #(.TIMEOUT(16'd8)) dut (
    .clk(clk),
    .nreset(nreset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .bus_address(bus_address),
    .bus_data(bus_data),
    .bus_rd(bus_rd),
    .bus_wr(bus_wr),
    .busy(busy),
    .err_timeout(err_timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: plain registers everywhere, a pop-on-read FIFO at 8'h20
  // returning C0, C1, C2, ... The slave holds the bus at 00 whenever the
  // master is not writing, so a stray master drive corrupts the value seen.
  logic [7:0] mem [256];
  int         fifo_idx;
  logic       preload;
  logic [7:0] slave_q;

  always_comb begin
    slave_q = 8'h00;
    if (bus_rd) begin
      slave_q = (bus_address == 8'h20) ? (8'hC0 + fifo_idx[7:0]) : mem[bus_address];
    end
  end

  assign bus_data = bus_wr ? 8'hzz : slave_q;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'hFE] <= 8'h11;
      mem[8'hFF] <= 8'h22;
      mem[8'h00] <= 8'h33;
      fifo_idx   <= 0;
    end else begin
      if (bus_wr) mem[bus_address] <= bus_data;
      if (bus_rd && bus_address == 8'h20) fifo_idx <= fifo_idx + 1;
    end
  end

  // Bus monitor
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t        wr_q[$];
  logic [7:0] rd_q[$];
  int         tx_cycles;
  int         both_viol;
  int         drive_viol;
  int         consec_viol;
  int         err_cnt;
  logic       prev_strobe;

  initial begin
    tx_cycles = 0; both_viol = 0; drive_viol = 0; consec_viol = 0; err_cnt = 0;
    prev_strobe = 1'b0;
  end

  always @(negedge clk) begin
    if (nreset) begin
      if (bus_wr) wr_q.push_back({bus_address, bus_data});
      if (bus_rd) rd_q.push_back(bus_address);
      if (bus_rd && bus_wr) both_viol++;
      if (!bus_wr && !bus_rd && bus_data !== 8'h00) drive_viol++;
      if ((bus_rd || bus_wr) && prev_strobe) consec_viol++;
      if (err_timeout) err_cnt++;
      if (tx_valid) tx_cycles++;
      prev_strobe = bus_rd || bus_wr;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    rd_q.delete();
    tx_cycles = 0;
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("rx_ready_wait_%0h", b), rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  task automatic recv_byte(input logic [7:0] exp, input int stall, input string name);
    int         t = 0;
    logic [7:0] first;
    logic       stable;
    tx_ready = 1'b0;
    while (!tx_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_valid"}, tx_valid, 1);
    first  = tx_data;
    stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== first) stable = 1'b0;
    end
    if (stall > 0) chk({name, "_stable"}, stable, 1);
    chk(name, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [7:0] byte_at(input logic [31:0] x, input int i);
    return x[31-8*i -: 8];
  endfunction

  // Byte lists are written first-byte-leftmost.
  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    int          gap;
    logic [31:0] wd;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vt [8];

  initial begin
    int         n;
    int         pulse_at;
    logic       busy_after;
    ev_t        e;
    logic [7:0] ra;

    vt[0] = '{8'h80, 8'h12, 0, 32'hA5000000, 32'h12000000, 32'hA5000000};
    vt[1] = '{8'h42, 8'hFE, 0, 32'h00000000, 32'hFEFF0000, 32'h11223300};
    vt[2] = '{8'hC2, 8'h40, 2, 32'h01020300, 32'h40414200, 32'h01020300};
    vt[3] = '{8'h42, 8'h40, 0, 32'h00000000, 32'h40414200, 32'h01020300};
    vt[4] = '{8'h81, 8'h50, 1, 32'h07080000, 32'h50500000, 32'h07080000};
    vt[5] = '{8'h00, 8'h50, 0, 32'h00000000, 32'h50000000, 32'h08000000};
    vt[6] = '{8'hC1, 8'hFF, 0, 32'hAABB0000, 32'hFF000000, 32'hAABB0000};
    vt[7] = '{8'h00, 8'h00, 0, 32'h00000000, 32'h00000000, 32'hBB000000};

    nreset   = 1'b0;
    preload  = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_bus_rd", bus_rd, 0);
    chk("rst_bus_wr", bus_wr, 0);
    chk("rst_bus_address", bus_address, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_bus_data", bus_data, 8'h00);
    nreset  = 1'b1;
    preload = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", rx_ready, 1);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 8; v++) begin
      clear_logs();
      n = int'(vt[v].cmd[5:0]) + 1;
      send_byte(vt[v].cmd, vt[v].gap);
      send_byte(vt[v].addr, vt[v].gap);
      if (vt[v].cmd[7]) begin
        for (int i = 0; i < n; i++) send_byte(byte_at(vt[v].wd, i), vt[v].gap);
      end else begin
        for (int i = 0; i < n; i++)
          recv_byte(byte_at(vt[v].ed, i), i % 2, $sformatf("v%0d_tx%0d", v, i));
      end
      wait_idle($sformatf("v%0d", v));
      if (vt[v].cmd[7]) begin
        chk($sformatf("v%0d_wr_count", v), wr_q.size(), n);
        chk($sformatf("v%0d_rd_count", v), rd_q.size(), 0);
        chk($sformatf("v%0d_tx_silent", v), tx_cycles, 0);
        for (int i = 0; i < n; i++) begin
          if (i < wr_q.size()) e = wr_q[i];
          else e = 16'hxxxx;
          chk($sformatf("v%0d_wr_addr%0d", v, i), e.a, byte_at(vt[v].ea, i));
          chk($sformatf("v%0d_wr_data%0d", v, i), e.d, byte_at(vt[v].ed, i));
        end
      end else begin
        chk($sformatf("v%0d_rd_count", v), rd_q.size(), n);
        chk($sformatf("v%0d_wr_count", v), wr_q.size(), 0);
        for (int i = 0; i < n; i++) begin
          if (i < rd_q.size()) ra = rd_q[i];
          else ra = 8'hxx;
          chk($sformatf("v%0d_rd_addr%0d", v, i), ra, byte_at(vt[v].ea, i));
        end
      end
    end

    // Fixed-address FIFO read with 5-cycle tx back-pressure per byte
    clear_logs();
    send_byte(8'h03, 0);
    send_byte(8'h20, 0);
    for (int i = 0; i < 4; i++) recv_byte(8'hC0 + 8'(i), 5, $sformatf("fifo_tx%0d", i));
    wait_idle("fifo");
    chk("fifo_rd_count", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rd_q.size()) ra = rd_q[i];
      else ra = 8'hxx;
      chk($sformatf("fifo_rd_addr%0d", i), ra, 8'h20);
    end

    // Timeout: two-byte write stalls after the first data byte
    clear_logs();
    chk("to_err_before", err_cnt, 0);
    send_byte(8'h81, 0);
    send_byte(8'h10, 0);
    send_byte(8'h55, 0);
    pulse_at   = -1;
    busy_after = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (err_timeout && pulse_at < 0) pulse_at = i;
      if (i == 9) busy_after = busy;
      @(negedge clk);
    end
    chk("to_pulse_cycle", pulse_at, 8);
    chk("to_busy_after", busy_after, 0);
    chk("to_err_count", err_cnt, 1);
    chk("to_wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) e = wr_q[0];
    else e = 16'hxxxx;
    chk("to_wr_addr", e.a, 8'h10);
    chk("to_wr_data", e.d, 8'h55);
    clear_logs();
    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    recv_byte(8'h55, 0, "to_readback");
    wait_idle("to_readback");
    chk("to_readback_rd_count", rd_q.size(), 1);

    // Reset while a 4-byte read waits in S_RSEND
    clear_logs();
    send_byte(8'h43, 0);
    send_byte(8'h60, 0);
    begin
      int t = 0;
      while (!tx_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    chk("rr_tx_valid_pre", tx_valid, 1);
    nreset = 1'b0;
    @(negedge clk);
    chk("rr_tx_valid", tx_valid, 0);
    chk("rr_bus_rd", bus_rd, 0);
    chk("rr_busy", busy, 0);
    chk("rr_bus_address", bus_address, 8'h00);
    chk("rr_rx_ready", rx_ready, 0);
    chk("rr_rd_count", rd_q.size(), 1);
    nreset = 1'b1;
    @(negedge clk);
    chk("rr_rx_ready_after", rx_ready, 1);
    clear_logs();
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    recv_byte(8'hA5, 2, "rr_fresh");
    wait_idle("rr_fresh");
    chk("rr_fresh_rd_count", rd_q.size(), 1);

    chk("strobe_overlap", both_viol, 0);
    chk("stray_drive", drive_viol, 0);
    chk("consecutive_strobes", consec_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
